// File: rtl/fft_agu.sv
// Address generator for an in-place radix-2 DIT FFT: butterfly issue, stage sequencing, write-back drain.
// Define FFT_AGU_WB_CHECK_EN to enable the sticky write-back count error flag (wb_err tied low otherwise).
module fft_agu #(
  parameter int N             = 32,
  parameter int address_width = $clog2(N),
  parameter int stage_width   = $clog2(address_width) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stall,
  input  logic                     wb_valid,
  output logic                     o_valid,
  output logic [address_width-1:0] rd_address1,
  output logic [address_width-1:0] rd_address2,
  output logic [address_width-2:0] twiddle_index,
  output logic [stage_width-1:0]   stage,
  output logic                     busy,
  output logic                     done,
  output logic                     wb_err
);
  localparam int KW = address_width - 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [KW-1:0]            K_LAST  = KW'(N/2 - 1);
  localparam logic [address_width-1:0] WB_FULL = address_width'(N/2);
  localparam logic [stage_width-1:0]   S_LAST  = stage_width'(address_width - 1);

  logic [1:0]               state;
  logic [KW-1:0]            k;
  logic [address_width-1:0] wb_cnt;
  logic                     wb_count_en;

  assign o_valid     = (state == ISSUE) && !stall;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign wb_count_en = wb_valid && ((state == ISSUE) || (state == DRAIN));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      k      <= '0;
      stage  <= '0;
      wb_cnt <= '0;
    end else begin
      // saturate so stray strobes cannot wrap the count back below N/2
      if (wb_count_en && (wb_cnt != WB_FULL)) wb_cnt <= wb_cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          state  <= ISSUE;
          k      <= '0;
          stage  <= '0;
          wb_cnt <= '0;
        end
        ISSUE: if (o_valid) begin
          k <= k + 1'b1;
          if (k == K_LAST) state <= DRAIN;
        end
        DRAIN: if (wb_cnt == WB_FULL) begin
          if (stage != S_LAST) begin
            stage  <= stage + 1'b1;
            k      <= '0;
            wb_cnt <= '0;
            state  <= ISSUE;
          end else begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // butterfly k of stage s: group k>>s, offset k mod 2^s, partner 2^s above
  logic [address_width-1:0] kx, half, pos, grp, a1, tw_full;
  logic [stage_width-1:0]   tw_shift;

  always_comb begin
    kx            = {1'b0, k};
    half          = address_width'(1) << stage;
    pos           = kx & (half - 1'b1);
    grp           = kx >> stage;
    a1            = (grp << (stage + 1'b1)) | pos;
    tw_shift      = S_LAST - stage;
    tw_full       = pos << tw_shift;
    rd_address1   = '0;
    rd_address2   = '0;
    twiddle_index = '0;
    if (busy) begin
      rd_address1   = a1;
      rd_address2   = a1 + half;
      twiddle_index = tw_full[address_width-2:0];
    end
  end

`ifdef FFT_AGU_WB_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)
      wb_err <= 1'b0;
    else if (wb_valid && ((state == IDLE) || (wb_count_en && (wb_cnt == WB_FULL))))
      wb_err <= 1'b1;
  end
`else
  assign wb_err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_agu.sv
// Randomized bench for fft_agu (N=8): butterfly-list reference model plus directed stall/drain/abort/error cases.
module tb_fft_agu;
  localparam int N     = 8;
  localparam int AW    = 3;
  localparam int SW    = 3;
  localparam int L     = 3;
  localparam int HB    = N / 2;
  localparam int TOTAL = L * N / 2;
`ifdef FFT_AGU_WB_CHECK_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0, wb_valid = 1'b0;
  logic o_valid, busy, done, wb_err;
  logic [AW-1:0] rd_address1, rd_address2;
  logic [AW-2:0] twiddle_index;
  logic [SW-1:0] stage;

  always #5 clk = ~clk;

  fft_agu #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .wb_valid(wb_valid),
    .o_valid(o_valid), .rd_address1(rd_address1), .rd_address2(rd_address2),
    .twiddle_index(twiddle_index), .stage(stage), .busy(busy), .done(done), .wb_err(wb_err)
  );

  int nchk = 0, npass = 0;
  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // write-back unit stand-in: echoes each issue dly edges later
  logic [15:0] hist = '0;
  bit echo_en = 1'b0;
  int dly = 6;
  int err_exp = 0;
  always @(posedge clk) hist <= {hist[14:0], o_valid & ~reset};

  // reference: the full list of butterflies for one transform, in issue order
  typedef struct { int a1; int a2; int tw; int st; } bf_t;
  bf_t q[$];
  bf_t log_q[$];
  bit  active = 1'b0;
  int  wb_age = 99;

  always @(negedge clk) begin
    bf_t e;
    #1;
    chk("busy", busy, active);
    chk("wb_err", wb_err, err_exp);
    if (reset) begin
      q.delete();
      active = 1'b0;
    end else begin
      if (o_valid) begin
        chk("issue_under_stall", stall, 0);
        if (q.size() == 0) chk("spurious_issue", 1, 0);
        else begin
          e = q.pop_front();
          chk("a1", rd_address1, e.a1);
          chk("a2", rd_address2, e.a2);
          chk("tw", twiddle_index, e.tw);
          chk("stage", stage, e.st);
          log_q.push_back('{rd_address1, rd_address2, twiddle_index, stage});
        end
      end else if (active && q.size() > 0 && ((TOTAL - q.size()) % HB) != 0) begin
        // mid-stage: only a stall may hold back issue, and addresses stay on the next butterfly
        chk("stall_gate", stall, 1);
        chk("hold_a1", rd_address1, q[0].a1);
        chk("hold_a2", rd_address2, q[0].a2);
      end
      if (wb_valid) wb_age = 0;
      else if (wb_age < 99) wb_age++;
      if (done) begin
        chk("done_when_complete", int'(active && q.size() == 0), 1);
        chk("done_latency", wb_age, 2);
        active = 1'b0;
      end
      if (start && !busy) begin
        log_q.delete();
        for (int s = 0; s < L; s++) begin
          int h;
          h = 1 << s;
          for (int base = 0; base < N; base += 2 * h)
            for (int j = 0; j < h; j++)
              q.push_back('{base + j, base + j + h, j * (N / (2 * h)), s});
        end
        active = 1'b1;
      end
    end
  end

  task automatic tick(input bit rnd);
    @(negedge clk);
    wb_valid = echo_en && hist[dly-1];
    stall    = rnd && ($urandom_range(0, 3) == 0);
  endtask

  task automatic wait_done(input bit rnd);
    int dn = 0, tail = 0, g = 0;
    do begin
      tick(rnd);
      start = rnd && dn == 0 && busy && ($urandom_range(0, 5) == 0);
      #2;
      if (done) dn++;
      if (dn > 0) tail++;
      g++;
    end while (tail < 4 && g < 3000);
    start = 1'b0;
    chk("done_pulses", dn, 1);
  endtask

  task automatic do_reset();
    tick(0); reset = 1'b1;
    tick(0); reset = 1'b0; err_exp = 0;
  endtask

  int exp_tab [12][3] = '{'{0,1,0}, '{2,3,0}, '{4,5,0}, '{6,7,0},
                          '{0,2,0}, '{1,3,2}, '{4,6,0}, '{5,7,2},
                          '{0,4,0}, '{1,5,1}, '{2,6,2}, '{3,7,3}};

  initial begin
    int ndone;
    bit found;
    tick(0); tick(0);
    #2;
    chk("rst_busy", busy, 0);     chk("rst_ovalid", o_valid, 0);
    chk("rst_done", done, 0);     chk("rst_err", wb_err, 0);
    chk("rst_a1", rd_address1, 0); chk("rst_a2", rd_address2, 0);
    chk("rst_tw", twiddle_index, 0); chk("rst_stage", stage, 0);
    tick(0); reset = 1'b0;

    // pinned N=8 sequence, write-back 6 cycles after issue
    echo_en = 1'b1; dly = 6;
    tick(0); start = 1'b1;
    wait_done(0);
    chk("pin_count", log_q.size(), 12);
    for (int i = 0; i < 12 && i < log_q.size(); i++) begin
      chk("pin_a1", log_q[i].a1, exp_tab[i][0]);
      chk("pin_a2", log_q[i].a2, exp_tab[i][1]);
      chk("pin_tw", log_q[i].tw, exp_tab[i][2]);
    end

    // three stall cycles at stage 0, k=2
    tick(0); start = 1'b1;
    tick(0); start = 1'b0;
    found = 1'b0;
    for (int g = 0; g < 50 && !found; g++) begin
      if (busy && stage == 0 && rd_address1 == 4) found = 1'b1;
      else tick(0);
    end
    chk("stall_point_found", found, 1);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      #2;
      chk("stall_ovalid", o_valid, 0);
      chk("stall_a1", rd_address1, 4);
      chk("stall_a2", rd_address2, 5);
      tick(0);
    end
    wait_done(0);

    // write-back withheld after stage 0, then one surplus strobe
    echo_en = 1'b0;
    tick(0); start = 1'b1;
    tick(0); start = 1'b0;
    repeat (12) tick(0);
    #2;
    chk("drain_stage", stage, 0); chk("drain_busy", busy, 1); chk("drain_ovalid", o_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0); wb_valid = 1'b1;
      #2; chk("drain_hold_stage", stage, 0);
    end
    tick(0); wb_valid = 1'b1;
    #2; chk("drain_4th_stage", stage, 0); chk("drain_4th_ovalid", o_valid, 0);
    tick(0); err_exp = ERR_ON; echo_en = 1'b1;
    #2; chk("advance_stage", stage, 1); chk("advance_ovalid", o_valid, 1);
    wait_done(0);
    repeat (3) tick(0);
    #2; chk("err_held", wb_err, ERR_ON);
    do_reset();

    // strobe while idle
    echo_en = 1'b0;
    tick(0); wb_valid = 1'b1;
    tick(0); err_exp = ERR_ON;
    repeat (2) tick(0);
    #2; chk("err_idle", wb_err, ERR_ON);
    do_reset();

    // abort with reset on the stage-1 k=1 issue
    echo_en = 1'b1; dly = 6;
    tick(0); start = 1'b1;
    tick(0); start = 1'b0;
    found = 1'b0;
    for (int g = 0; g < 200 && !found; g++) begin
      if (busy && stage == 1 && rd_address1 == 1 && o_valid) found = 1'b1;
      else tick(0);
    end
    chk("abort_point_found", found, 1);
    reset = 1'b1; echo_en = 1'b0;
    tick(0); reset = 1'b0;
    #2;
    chk("abort_busy", busy, 0); chk("abort_ovalid", o_valid, 0); chk("abort_stage", stage, 0);
    ndone = 0;
    repeat (30) begin
      tick(0); #2;
      if (done || o_valid) ndone++;
    end
    chk("abort_quiet", ndone, 0);

    // randomized stall, start noise and write-back latency
    echo_en = 1'b1;
    for (int t = 0; t < 6; t++) begin
      dly = $urandom_range(1, 12);
      repeat ($urandom_range(1, 4)) tick(0);
      tick(1); start = 1'b1;
      wait_done(1);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
